// File: rtl/opdecode_fifo.sv
// opdecode_fifo: screens NOP/illegal shape codes and queues decoded commands in a DEPTH-entry FIFO.
// Defining OPDEC_ERRCNT_EN adds err_count, a saturating count of illegal commands accepted.
module opdecode_fifo #(
  parameter int CMD_W = 96,
  parameter int SHAPE_W = 4,
  parameter int COLOR_W = 16,
  parameter int NUM_SHAPES = 8,
  parameter int DEPTH = 4,
  localparam int OPDATA_W = CMD_W - SHAPE_W - COLOR_W,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [CMD_W-1:0]    in_cmd,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SHAPE_W-1:0]  out_shape,
  output logic [COLOR_W-1:0]  out_color,
  output logic [OPDATA_W-1:0] out_opdata,
  output logic [CNT_W-1:0]    occupancy,
  output logic                illegal
`ifdef OPDEC_ERRCNT_EN
  ,
  output logic [7:0]          err_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [SHAPE_W-1:0] mem_shape [DEPTH];
  logic [COLOR_W-1:0] mem_color [DEPTH];
  logic [OPDATA_W-1:0] mem_opdata [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [SHAPE_W-1:0] s;
  logic accept, nop, bad, push, pop;
  always_comb begin
    s = in_cmd[CMD_W-1 -: SHAPE_W];
    in_ready = occupancy != CNT_W'(DEPTH);
    out_valid = occupancy != '0;
    accept = in_valid && in_ready;
    nop = s == '0;
    bad = 32'(s) >= NUM_SHAPES;
    push = accept && !nop && !bad && !flush;
    pop = out_valid && out_ready && !flush;
    out_shape = out_valid ? mem_shape[rd_ptr] : '0;
    out_color = out_valid ? mem_color[rd_ptr] : '0;
    out_opdata = out_valid ? mem_opdata[rd_ptr] : '0;
  end
  // storage needs no reset: occupancy masks stale entries
  always_ff @(posedge clk)
    if (push) begin
      mem_shape[wr_ptr] <= s;
      mem_color[wr_ptr] <= in_cmd[CMD_W-SHAPE_W-1 -: COLOR_W];
      mem_opdata[wr_ptr] <= in_cmd[OPDATA_W-1:0];
    end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occupancy <= '0;
      illegal <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occupancy <= '0;
      illegal <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
      illegal <= accept && bad;
    end
`ifdef OPDEC_ERRCNT_EN
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) err_count <= '0;
    else if (accept && bad && !flush && err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
endmodule
